// File: rtl/qspi_rx_word_packer_if.sv
// RX FIFO read port between the QSPI word packer (slave) and the AHB read path (master).
interface qspi_rx_word_packer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             rd_en;
  logic [31:0]      rd_data;
  logic [2:0]       rd_bytes;
  logic             rx_empty;
  logic             rx_full;
  logic [LVL_W-1:0] rx_level;
  logic             rx_overflow;
  logic             ovf_clr;

  modport master (
    output rd_en,
    output ovf_clr,
    input  rd_data,
    input  rd_bytes,
    input  rx_empty,
    input  rx_full,
    input  rx_level,
    input  rx_overflow
  );

  modport slave (
    input  rd_en,
    input  ovf_clr,
    output rd_data,
    output rd_bytes,
    output rx_empty,
    output rx_full,
    output rx_level,
    output rx_overflow
  );
endinterface

// File: rtl/qspi_rx_word_packer.sv
// Counts QSPI sampling pulses, forms full or partial words from the sampling register
// and queues them, byte-reordered, in a first-word-fall-through RX FIFO.
module qspi_rx_word_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter bit BYTE_SWAP  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_start,
  input  logic                        xfer_last,
  input  logic                        sample_en,
  input  logic                        use_1_io_lines_in,
  input  logic                        use_2_io_lines_in,
  input  logic                        use_4_io_lines_in,
  input  logic [31:0]                 sample_data,
  output logic                        rx_busy,
  qspi_rx_word_packer_if.slave        rd_if
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t        state_r;
  logic [5:0]    bit_cnt_r;
  logic          push_pending_r;
  logic [2:0]    pend_nbytes_r;
  logic          rx_busy_r;

  logic [31:0]   mem_r    [FIFO_DEPTH];
  logic [2:0]    nb_mem_r [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [LW-1:0] count_r;
  logic [31:0]   rd_data_r;
  logic [2:0]    rd_bytes_r;
  logic          rx_empty_r;
  logic          rx_full_r;
  logic          rx_overflow_r;

  logic [5:0]    inc_s;
  logic [5:0]    sum_s;
  logic [5:0]    cnt_post_s;
  logic          push_s;
  logic          pop_s;
  logic          accept_s;
  logic          ovf_set_s;
  logic [31:0]   push_word_s;
  logic [31:0]   head_word_s;
  logic [2:0]    head_bytes_s;
  logic [LW-1:0] count_n_s;
  logic [AW-1:0] rd_nxt_s;

  // Received byte k sits at sd[8(n-k)-1 -: 8]; either spread it little-endian or keep raw order.
  function automatic logic [31:0] reorder_word(input logic [31:0] sd, input logic [2:0] n);
    logic [31:0] w;
    int          nb;
    w  = 32'd0;
    nb = int'(n);
    for (int k = 0; k < 4; k++) begin
      if (k < nb) begin
        if (BYTE_SWAP) begin
          w[8*k +: 8] = sd[8*(nb-k)-8 +: 8];
        end else begin
          w[8*k +: 8] = sd[8*k +: 8];
        end
      end else begin
        w[8*k +: 8] = 8'd0;
      end
    end
    return w;
  endfunction

  // Bits gained this cycle (single wins over dual over quad) and the clamped post-update count.
  always_comb begin
    inc_s      = 6'd0;
    sum_s      = 6'd0;
    cnt_post_s = 6'd0;
    if ((state_r != ST_COLLECT) || !sample_en) begin
      inc_s = 6'd0;
    end else if (use_1_io_lines_in) begin
      inc_s = 6'd1;
    end else if (use_2_io_lines_in) begin
      inc_s = 6'd2;
    end else if (use_4_io_lines_in) begin
      inc_s = 6'd4;
    end else begin
      inc_s = 6'd0;
    end
    sum_s = bit_cnt_r + inc_s;
    if (sum_s >= 6'd32) begin
      cnt_post_s = 6'd32;
    end else begin
      cnt_post_s = sum_s;
    end
  end

  // FIFO push/pop qualification and next occupancy; rx_start suppresses both.
  always_comb begin
    push_s      = push_pending_r & ~rx_start;
    pop_s       = rd_if.rd_en & (count_r != LVL_ZERO) & ~rx_start;
    accept_s    = push_s & ((count_r != LVL_FULL) | pop_s);
    ovf_set_s   = push_s & ~accept_s;
    push_word_s = reorder_word(sample_data, pend_nbytes_r);
    rd_nxt_s    = rd_ptr_r + PTR_ONE;
    count_n_s   = count_r;
    if (accept_s && !pop_s) begin
      count_n_s = count_r + LVL_ONE;
    end else if (pop_s && !accept_s) begin
      count_n_s = count_r - LVL_ONE;
    end else begin
      count_n_s = count_r;
    end
  end

  // Next head entry, so rd_data/rd_bytes can be registered yet stay first-word-fall-through.
  always_comb begin
    head_word_s  = 32'd0;
    head_bytes_s = 3'd0;
    if (count_n_s == LVL_ZERO) begin
      head_word_s  = 32'd0;
      head_bytes_s = 3'd0;
    end else if (pop_s && (count_r == LVL_ONE)) begin
      head_word_s  = push_word_s;
      head_bytes_s = pend_nbytes_r;
    end else if (pop_s) begin
      head_word_s  = mem_r[rd_nxt_s];
      head_bytes_s = nb_mem_r[rd_nxt_s];
    end else if (count_r == LVL_ZERO) begin
      head_word_s  = push_word_s;
      head_bytes_s = pend_nbytes_r;
    end else begin
      head_word_s  = mem_r[rd_ptr_r];
      head_bytes_s = nb_mem_r[rd_ptr_r];
    end
  end

  // Packer FSM: bit counting, full/partial word detection and push scheduling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      bit_cnt_r      <= 6'd0;
      push_pending_r <= 1'b0;
      pend_nbytes_r  <= 3'd0;
      rx_busy_r      <= 1'b0;
    end else if (rx_start) begin
      state_r        <= ST_COLLECT;
      bit_cnt_r      <= 6'd0;
      push_pending_r <= 1'b0;
      pend_nbytes_r  <= 3'd0;
      rx_busy_r      <= 1'b1;
    end else begin
      push_pending_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r <= 6'd0;
          rx_busy_r <= 1'b0;
        end
        ST_COLLECT: begin
          if (xfer_last) begin
            state_r   <= ST_IDLE;
            rx_busy_r <= 1'b0;
            bit_cnt_r <= 6'd0;
            if (cnt_post_s >= 6'd8) begin
              push_pending_r <= 1'b1;
              pend_nbytes_r  <= (cnt_post_s == 6'd32) ? 3'd4 : {1'b0, cnt_post_s[4:3]};
            end
          end else if (cnt_post_s == 6'd32) begin
            bit_cnt_r      <= 6'd0;
            push_pending_r <= 1'b1;
            pend_nbytes_r  <= 3'd4;
          end else begin
            bit_cnt_r <= cnt_post_s;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bit_cnt_r <= 6'd0;
          rx_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and registered head/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r      <= PTR_ZERO;
      wr_ptr_r      <= PTR_ZERO;
      count_r       <= LVL_ZERO;
      rd_data_r     <= 32'd0;
      rd_bytes_r    <= 3'd0;
      rx_empty_r    <= 1'b1;
      rx_full_r     <= 1'b0;
      rx_overflow_r <= 1'b0;
    end else if (rx_start) begin
      rd_ptr_r      <= PTR_ZERO;
      wr_ptr_r      <= PTR_ZERO;
      count_r       <= LVL_ZERO;
      rd_data_r     <= 32'd0;
      rd_bytes_r    <= 3'd0;
      rx_empty_r    <= 1'b1;
      rx_full_r     <= 1'b0;
      rx_overflow_r <= rx_overflow_r & ~rd_if.ovf_clr;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_nxt_s;
      end
      count_r       <= count_n_s;
      rd_data_r     <= head_word_s;
      rd_bytes_r    <= head_bytes_s;
      rx_empty_r    <= (count_n_s == LVL_ZERO);
      rx_full_r     <= (count_n_s == LVL_FULL);
      rx_overflow_r <= ovf_set_s | (rx_overflow_r & ~rd_if.ovf_clr);
    end
  end

  // Storage array; entries are only observed through the occupancy-qualified head.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r]    <= push_word_s;
      nb_mem_r[wr_ptr_r] <= pend_nbytes_r;
    end
  end

  assign rd_if.rd_data     = rd_data_r;
  assign rd_if.rd_bytes    = rd_bytes_r;
  assign rd_if.rx_empty    = rx_empty_r;
  assign rd_if.rx_full     = rx_full_r;
  assign rd_if.rx_level    = count_r;
  assign rd_if.rx_overflow = rx_overflow_r;
  assign rx_busy           = rx_busy_r;

endmodule

// File: doc/qspi_rx_word_packer.md
Name: qspi_rx_word_packer

Overview:
Downstream consumer of the QSPI sampling shift register. Counts sampling pulses according to the active I/O width and determines when 32 bits (or a final partial word) have accumulated. It then byte-reorders the word and pushes it into a small first-word-fall-through RX FIFO that the AHB slave read path pops.

Parameters:
FIFO_DEPTH, 4, RX FIFO entries; power of 2, at least 2.
BYTE_SWAP, 1, 1 = first-received byte lands in rd_data[7:0] (AHB little-endian); 0 = raw shift-register order.

Ports:
clk  input  1  system clock (HCLK)
rst_n  input  1  asynchronous active-low reset
rx_start  input  1  pulse; starts a read data phase; clears counter, pending push and FIFO
xfer_last  input  1  pulse; the data phase ends (same cycle as, or after, the final sample_en)
sample_en  input  1  sampling pulse; same pulse that drives the sampling register
use_1_io_lines_in  input  1  single mode; +1 bit per sample
use_2_io_lines_in  input  1  dual mode; +2 bits per sample
use_4_io_lines_in  input  1  quad mode; +4 bits per sample
sample_data  input  32  sampling register contents; newest bits in the LSBs
rd_en  input  1  pop the FIFO head
rd_data  output  32  FIFO head word (FWFT)
rd_bytes  output  3  number of valid bytes in rd_data (1..4)
rx_empty  output  1  FIFO empty
rx_full  output  1  FIFO full
rx_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
rx_overflow  output  1  sticky; a word was dropped
ovf_clr  input  1  clears rx_overflow
rx_busy  output  1  packer is in the COLLECT state

Behaviour:
- Reset values: state IDLE, bit_cnt=0, push_pending=0, FIFO empty. Outputs reset to rd_data=0, rd_bytes=0, rx_empty=1, rx_full=0, rx_level=0, rx_overflow=0, rx_busy=0.
- FSM states are IDLE and COLLECT.
  - IDLE -> COLLECT on rx_start.
  - COLLECT -> IDLE on xfer_last.
  - rx_start while in COLLECT restarts the phase and stays in COLLECT.
  - rx_busy=1 exactly when the state is COLLECT.
- Increment per sample: 1, 2 or 4 bits, chosen with priority 1 > 2 > 4. If no mode line is set, the sample is not counted. sample_en in IDLE is ignored.
- bit_cnt is 6 bits wide. bit_cnt+inc clamps at 32; overshoot bits are discarded.
- Full word, cycle T: sample_en brings bit_cnt to 32. bit_cnt then returns to 0 and push_pending is set with nbytes=4.
- Full word, cycle T+1: sample_data now contains the new bits. The word is written at the end of T+1 and is visible on rd_data at T+2.
  - A sample_en at T+1 is counted normally; back-to-back pulses are legal.
- Partial word: on xfer_last, evaluate the post-update count c (including any same-cycle sample).
  - c=0 or c=32: no extra push.
  - 8<=c<32: push next cycle with nbytes=floor(c/8); leftover bits are dropped.
  - c<8: nothing is pushed.
  - In every case bit_cnt is cleared.
- Reordering: received byte k (0 = first) is sample_data[8*(n-k)-1 : 8*(n-k)-8].
  - BYTE_SWAP=1: byte k is placed at word[8k+7:8k].
  - BYTE_SWAP=0: word = sample_data with the low 8n bits kept.
  - Unused upper bytes are 0. The stored rd_bytes is n.
- FIFO:
  - rd_data and rd_bytes show the head entry, or 0 when empty.
  - rd_en when empty is ignored.
  - Push when full (no pop in the same cycle): the word is dropped and rx_overflow is set.
  - Push and pop in the same cycle when full: both succeed and the level is unchanged.
  - Push and pop in the same cycle when empty: the push succeeds; the pop is ignored.
- rx_overflow is sticky. It clears on ovf_clr; a set and ovf_clr in the same cycle leaves it set.
- rx_start has priority over everything in its cycle: FIFO flushed, bit_cnt=0, push_pending=0. The same-cycle sample_en, rd_en and xfer_last are ignored. rx_overflow is unaffected.
- Asynchronous reset mid-operation returns all state to the reset values immediately.

Test Plan:
- Quad, BYTE_SWAP=1: rx_start, then 8 sample_en with a sampling model producing 0x9F,0xEF,0x40,0x18 -> rd_data=0x1840EF9F at T+2, rd_bytes=4, rx_level=1; rd_en -> rx_empty=1.
- Single mode: 32 sample_en pulses on consecutive cycles -> exactly one push. With BYTE_SWAP=0, rd_data equals sample_data from the cycle after the 32nd pulse.
- Dual mode: 12 samples (24 bits, bytes 0xAA,0xBB,0xCC), xfer_last on the 12th -> rd_data=0x00CCBBAA, rd_bytes=3. A second run of 3 samples (6 bits) then xfer_last -> no push.
- FIFO_DEPTH=4: five full words pushed without pops -> rx_full=1, rx_level=4, fifth word dropped, rx_overflow=1. Pop plus push in the same cycle while full -> level stays 4. ovf_clr -> rx_overflow=0.
- rx_start mid-word (bit_cnt=16) with two words queued -> rx_empty=1, rx_level=0. The next 32 bits form a clean fresh word.
- rst_n asserted while in COLLECT with push_pending=1 -> all outputs return to reset values, no push occurs, rx_busy=0.
